// File: rtl/expr_stream_checker_pkg.sv
// Shared state encoding and ASCII constants for the expression stream checker.
package expr_pkg;

    typedef enum logic [1:0] {
        EXP_OPND = 2'b00,
        IN_NUM   = 2'b01,
        OPND_END = 2'b10,
        ERR      = 2'b11
    } state_t;

    localparam logic [7:0] CH_LP  = 8'h28;
    localparam logic [7:0] CH_RP  = 8'h29;
    localparam logic [7:0] CH_EQ  = 8'h3D;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_DIV = 8'h2F;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;

    localparam int DCNT_W = 4;

endpackage

// File: rtl/expr_stream_checker_if.sv
// Character stream in, syntax status and verdict out.
interface expr_stream_checker_if #(
    parameter int DEPTH_W = 3
);
    logic               in_valid;
    logic [7:0]         in;
    logic               out;
    logic               err;
    logic [DEPTH_W-1:0] depth;
    logic               done;
    logic               accept;

    modport master (output in_valid, in, input out, err, depth, done, accept);
    modport slave  (input in_valid, in, output out, err, depth, done, accept);
endinterface

// File: rtl/expr_stream_checker_char_class.sv
// One-hot classification of an incoming ASCII byte.
module expr_char_class
    import expr_pkg::*;
#(
    parameter bit ALLOW_SPACE = 1'b1
) (
    input  logic [7:0] in,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_lp,
    output logic       is_rp,
    output logic       is_eq,
    output logic       is_sp,
    output logic       is_bad
);
    always_comb begin
        is_digit = (in >= CH_0) && (in <= CH_9);
        is_op    = (in == CH_ADD) || (in == CH_SUB) || (in == CH_MUL) || (in == CH_DIV);
        is_lp    = (in == CH_LP);
        is_rp    = (in == CH_RP);
        is_eq    = (in == CH_EQ);
        is_sp    = ALLOW_SPACE && (in == CH_SP);
        is_bad   = !(is_digit || is_op || is_lp || is_rp || is_eq || is_sp);
    end
endmodule

// File: rtl/expr_stream_checker.sv
// Streaming syntax checker: operand (op operand)*, '=' ends the expression.
//  state    | meaning
//  EXP_OPND | expecting an operand
//  IN_NUM   | inside a number literal
//  OPND_END | operand complete, expecting op, ')' or '='
//  ERR      | syntax error, held until '='
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int DEPTH_W     = 3,
    parameter int MAX_DIGITS  = 4,
    parameter bit ALLOW_SPACE = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    expr_stream_checker_if.slave bus
);
    state_t              state, state_nxt;
    logic [DEPTH_W-1:0]  depth, depth_nxt;
    logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
    logic                done, done_nxt;
    logic                accept, accept_nxt;
    logic                complete;

    logic is_digit, is_op, is_lp, is_rp, is_eq, is_sp, is_bad;

    expr_char_class #(.ALLOW_SPACE(ALLOW_SPACE)) u_class (
        .in       (bus.in),
        .is_digit (is_digit),
        .is_op    (is_op),
        .is_lp    (is_lp),
        .is_rp    (is_rp),
        .is_eq    (is_eq),
        .is_sp    (is_sp),
        .is_bad   (is_bad)
    );

    assign complete = ((state == IN_NUM) || (state == OPND_END)) && (depth == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= EXP_OPND;
            depth  <= '0;
            dcnt   <= '0;
            done   <= 1'b0;
            accept <= 1'b0;
        end else begin
            state  <= state_nxt;
            depth  <= depth_nxt;
            dcnt   <= dcnt_nxt;
            done   <= done_nxt;
            accept <= accept_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        depth_nxt  = depth;
        dcnt_nxt   = dcnt;
        done_nxt   = 1'b0;
        accept_nxt = 1'b0;
        if (bus.in_valid) begin
            if (is_eq) begin
                done_nxt   = 1'b1;
                accept_nxt = complete;
                state_nxt  = EXP_OPND;
                depth_nxt  = '0;
                dcnt_nxt   = '0;
            end else begin
                unique case (state)
                    EXP_OPND: begin
                        if (is_digit) begin
                            state_nxt = IN_NUM;
                            dcnt_nxt  = DCNT_W'(1);
                        end else if (is_lp) begin
                            if (depth == '1) state_nxt = ERR;
                            else             depth_nxt = depth + 1'b1;
                        end else if (!is_sp) begin
                            state_nxt = ERR;
                        end
                    end
                    IN_NUM: begin
                        if (is_digit) begin
                            if (dcnt == DCNT_W'(MAX_DIGITS)) state_nxt = ERR;
                            else                             dcnt_nxt  = dcnt + 1'b1;
                        end else if (is_op) begin
                            state_nxt = EXP_OPND;
                            dcnt_nxt  = '0;
                        end else if (is_rp) begin
                            if (depth == '0) begin
                                state_nxt = ERR;
                            end else begin
                                state_nxt = OPND_END;
                                depth_nxt = depth - 1'b1;
                            end
                        end else if (is_sp) begin
                            state_nxt = OPND_END;
                        end else begin
                            state_nxt = ERR;
                        end
                    end
                    OPND_END: begin
                        if (is_op) begin
                            state_nxt = EXP_OPND;
                        end else if (is_rp) begin
                            if (depth == '0) state_nxt = ERR;
                            else             depth_nxt = depth - 1'b1;
                        end else if (!is_sp) begin
                            state_nxt = ERR;
                        end
                    end
                    default: state_nxt = ERR;
                endcase
            end
        end
    end

    // is_bad is implied by the fall-through branches above; kept for the classifier's one-hot contract
    logic unused_bad;
    assign unused_bad = is_bad;

    assign bus.out    = complete;
    assign bus.err    = (state == ERR);
    assign bus.depth  = depth;
    assign bus.done   = done;
    assign bus.accept = accept;
endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed character streams into three checker configurations; verdicts scored from a queue.
module tb_expr_stream_checker;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic       v = 1'b0;
    logic [7:0] ch = 8'h00;
    int         sel = 0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int dut; bit acc; } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    expr_stream_checker_if #(.DEPTH_W(3)) if0 ();
    expr_stream_checker_if #(.DEPTH_W(2)) if1 ();
    expr_stream_checker_if #(.DEPTH_W(3)) if2 ();

    assign if0.in_valid = v && (sel == 0);
    assign if1.in_valid = v && (sel == 1);
    assign if2.in_valid = v && (sel == 2);
    assign if0.in = ch;
    assign if1.in = ch;
    assign if2.in = ch;

    expr_stream_checker #(.DEPTH_W(3), .MAX_DIGITS(4), .ALLOW_SPACE(1'b1)) dut0 (.clk(clk), .clr_n(clr_n), .bus(if0.slave));
    expr_stream_checker #(.DEPTH_W(2), .MAX_DIGITS(4), .ALLOW_SPACE(1'b1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(if1.slave));
    expr_stream_checker #(.DEPTH_W(3), .MAX_DIGITS(4), .ALLOW_SPACE(1'b0)) dut2 (.clk(clk), .clr_n(clr_n), .bus(if2.slave));

    logic       o_v[3], e_v[3], d_v[3], a_v[3];
    logic [2:0] dep_v[3];
    assign o_v[0] = if0.out;  assign e_v[0] = if0.err;  assign d_v[0] = if0.done;  assign a_v[0] = if0.accept;
    assign o_v[1] = if1.out;  assign e_v[1] = if1.err;  assign d_v[1] = if1.done;  assign a_v[1] = if1.accept;
    assign o_v[2] = if2.out;  assign e_v[2] = if2.err;  assign d_v[2] = if2.done;  assign a_v[2] = if2.accept;
    assign dep_v[0] = if0.depth;
    assign dep_v[1] = {1'b0, if1.depth};
    assign dep_v[2] = if2.depth;

    task automatic chk(string name, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, sel, $time, act, expv);
        end
    endtask

    task automatic status(bit eo, bit ee, int ed);
        chk("out", int'(o_v[sel]), int'(eo));
        chk("err", int'(e_v[sel]), int'(ee));
        chk("depth", int'(dep_v[sel]), ed);
    endtask

    // Drive one character for one edge, then check the registered status after it.
    task automatic send(byte c, bit eo, bit ee, int ed, bit acc = 1'b0);
        exp_t e;
        v  = 1'b1;
        ch = c;
        if (c == "=") begin
            e.dut = sel;
            e.acc = acc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        v = 1'b0;
        status(eo, ee, ed);
    endtask

    task automatic idle(bit eo, bit ee, int ed);
        @(posedge clk);
        #1;
        status(eo, ee, ed);
    endtask

    always @(negedge clk) begin
        if (clr_n) begin
            for (int k = 0; k < 3; k++) begin
                if (d_v[k]) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_done dut%0d @%0t: got done=1 expected no verdict", k, $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.dut != k || a_v[k] != e.acc) begin
                            n_fail++;
                            $display("FAIL verdict dut%0d @%0t: got accept=%0d expected dut%0d accept=%0d",
                                     k, $time, a_v[k], e.dut, e.acc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            status(1'b0, 1'b0, 0);
            chk("reset_done", int'(d_v[k]), 0);
            chk("reset_accept", int'(a_v[k]), 0);
        end
        clr_n = 1'b1;
        sel = 0;
        idle(1'b0, 1'b0, 0);

        // "12+3="
        send("1", 1, 0, 0); send("2", 1, 0, 0); send("+", 0, 0, 0); send("3", 1, 0, 0);
        send("=", 0, 0, 0, 1'b1);
        // "(1*(2-3))="
        send("(", 0, 0, 1); send("1", 0, 0, 1); send("*", 0, 0, 1); send("(", 0, 0, 2);
        send("2", 0, 0, 2); send("-", 0, 0, 2); send("3", 0, 0, 2); send(")", 0, 0, 1);
        send(")", 1, 0, 0); send("=", 0, 0, 0, 1'b1);
        // "1+=" and "1++2="
        send("1", 1, 0, 0); send("+", 0, 0, 0); send("=", 0, 0, 0, 1'b0);
        send("1", 1, 0, 0); send("+", 0, 0, 0); send("+", 0, 1, 0); send("2", 0, 1, 0);
        send("=", 0, 0, 0, 1'b0);
        // digit limit
        send("1", 1, 0, 0); send("2", 1, 0, 0); send("3", 1, 0, 0); send("4", 1, 0, 0);
        send("5", 0, 1, 0); send("=", 0, 0, 0, 1'b0);
        send("1", 1, 0, 0); send("2", 1, 0, 0); send("3", 1, 0, 0); send("4", 1, 0, 0);
        send("=", 0, 0, 0, 1'b1);
        // leading zeros, back-to-back '='
        send("0", 1, 0, 0); send("0", 1, 0, 0); send("7", 1, 0, 0);
        send("=", 0, 0, 0, 1'b1); send("=", 0, 0, 0, 1'b0);
        // illegal bytes, unbalanced close
        send("1", 1, 0, 0); send("a", 0, 1, 0); send("=", 0, 0, 0, 1'b0);
        send(8'h80, 0, 1, 0); send("=", 0, 0, 0, 1'b0);
        send(")", 0, 1, 0); send("=", 0, 0, 0, 1'b0);
        send("(", 0, 0, 1); send("=", 0, 0, 0, 1'b0);
        // "1 + 2=" with idle cycles between characters
        send("1", 1, 0, 0); idle(1, 0, 0);
        send(" ", 1, 0, 0); idle(1, 0, 0);
        send("+", 0, 0, 0); idle(0, 0, 0);
        send(" ", 0, 0, 0); idle(0, 0, 0);
        send("2", 1, 0, 0); idle(1, 0, 0);
        send("=", 0, 0, 0, 1'b1); idle(0, 0, 0);

        sel = 1;
        send("(", 0, 0, 1); send("(", 0, 0, 2); send("(", 0, 0, 3); send("(", 0, 1, 3);
        send("=", 0, 0, 0, 1'b0);
        send(")", 0, 1, 0); send("=", 0, 0, 0, 1'b0);

        sel = 2;
        send("1", 1, 0, 0); idle(1, 0, 0);
        send(" ", 0, 1, 0); idle(0, 1, 0);
        send("+", 0, 1, 0); idle(0, 1, 0);
        send(" ", 0, 1, 0); idle(0, 1, 0);
        send("2", 0, 1, 0); idle(0, 1, 0);
        send("=", 0, 0, 0, 1'b0); idle(0, 0, 0);

        // asynchronous reset mid-expression
        sel = 0;
        send("(", 0, 0, 1); send("3", 0, 0, 1);
        clr_n = 1'b0;
        #1;
        status(1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        idle(1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
